// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the boot loader (optional BOOT_LOADER_CHECKSUM_EN adds ST_CSUM)
package boot_pkg;

    localparam int COUNT_W            = 16;
    localparam int WORD_BYTES         = 4;
    localparam int DEF_RELEASE_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_CNT_HI  = 3'd0,
        ST_CNT_LO  = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERR     = 3'd5
`ifdef BOOT_LOADER_CHECKSUM_EN
        ,
        ST_CSUM    = 3'd6
`endif
    } state_t;

    // States in which the loader is willing to take a byte from the stream.
    function automatic logic accepts_bytes(input state_t s);
        logic w_acc;
        w_acc = (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_LOAD);
`ifdef BOOT_LOADER_CHECKSUM_EN
        w_acc = w_acc || (s == ST_CSUM);
`endif
        return w_acc;
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// rtl/boot_word_asm.sv - big-endian byte-to-word assembler with one-cycle word_valid pulse
module boot_word_asm
    import boot_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;
    logic        w_last_byte;

    assign w_last_byte  = i_byte_valid && (r_byte_cnt == 2'(WORD_BYTES - 1));
    assign o_last_byte  = w_last_byte;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    // Shift bytes in MSB-first; the finished word is latched separately so the
    // next word's bytes never disturb the value being written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= w_last_byte;
            if (i_byte_valid) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_shift    <= {r_shift[15:0], i_byte};
            end
            if (w_last_byte) begin
                r_word <= {r_shift, i_byte};
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams a program image into instruction ROM then releases CPU reset (option: BOOT_LOADER_CHECKSUM_EN)
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_rom_we,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [31:0]       o_rom_wdata,
    output logic              o_cpu_rst,
    output logic              o_load_done,
    output logic              o_load_err
);

    localparam logic [COUNT_W:0] CAPACITY = (COUNT_W + 1)'(1) << ADDR_W;
    localparam logic [31:0]      REL_LAST = 32'(RELEASE_CYCLES - 1);
    // The cycle that finishes the image counts as the first release cycle, so a
    // single-cycle release skips the RELEASE state entirely.
    localparam state_t REL_ENTRY = (RELEASE_CYCLES == 1) ? ST_RUN : ST_RELEASE;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_rx_ready;
    logic                w_rx_ready_next;
    logic [7:0]          r_cnt_hi;
    logic [COUNT_W-1:0]  r_count;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [31:0]         r_rel_cnt;

    logic                w_xfer;
    logic [COUNT_W-1:0]  w_count_in;
    logic                w_too_big;
    logic [COUNT_W-1:0]  w_addr_ext;
    logic                w_last_word;
    logic                w_asm_valid;
    logic                w_last_byte;
    logic                w_rom_we;
    logic [31:0]         w_rom_wdata;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    assign w_xfer      = i_rx_valid && r_rx_ready;
    assign w_count_in  = {r_cnt_hi, i_rx_data};
    assign w_too_big   = {1'b0, w_count_in} > CAPACITY;
    assign w_addr_ext  = COUNT_W'(r_rom_addr);
    assign w_last_word = (w_addr_ext == (r_count - COUNT_W'(1)));
    assign w_asm_valid = w_xfer && (r_state == ST_LOAD);

    boot_word_asm u_word_asm (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte_valid (w_asm_valid),
        .i_byte       (i_rx_data),
        .o_last_byte  (w_last_byte),
        .o_word_valid (w_rom_we),
        .o_word       (w_rom_wdata)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CNT_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CNT_HI: begin
                if (w_xfer) w_state_next = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (w_xfer) begin
                    if (w_too_big) begin
                        w_state_next = ST_ERR;
                    end else if (w_count_in == '0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        w_state_next = ST_CSUM;
`else
                        w_state_next = REL_ENTRY;
`endif
                    end else begin
                        w_state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (w_last_byte && w_last_word) w_state_next = ST_CSUM;
`else
                if (w_rom_we && w_last_word) w_state_next = REL_ENTRY;
`endif
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_xfer) w_state_next = (i_rx_data == r_csum) ? REL_ENTRY : ST_ERR;
            end
`endif
            ST_RELEASE: begin
                if (r_rel_cnt == REL_LAST) w_state_next = ST_RUN;
            end
            ST_RUN:  w_state_next = ST_RUN;
            ST_ERR:  w_state_next = ST_ERR;
            default: w_state_next = ST_ERR;
        endcase
    end

    // Output decode: ready for the next cycle plus the state-driven status lines.
    always_comb begin
        w_rx_ready_next = accepts_bytes(w_state_next);
`ifndef BOOT_LOADER_CHECKSUM_EN
        // Nothing follows the final word, so stop taking bytes during its strobe.
        if ((r_state == ST_LOAD) && w_last_byte && w_last_word) w_rx_ready_next = 1'b0;
`endif
        o_cpu_rst   = (r_state != ST_RUN);
        o_load_done = (r_state == ST_RUN);
        o_load_err  = (r_state == ST_ERR);
    end

    // Count capture, ROM address stepping, release timer and running checksum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_ready <= 1'b0;
            r_cnt_hi   <= '0;
            r_count    <= '0;
            r_rom_addr <= '0;
            r_rel_cnt  <= 32'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_rx_ready <= w_rx_ready_next;
            if (w_xfer && (r_state == ST_CNT_HI)) r_cnt_hi <= i_rx_data;
            if (w_xfer && (r_state == ST_CNT_LO)) r_count  <= w_count_in;
            if (w_rom_we) r_rom_addr <= r_rom_addr + ADDR_W'(1);
            r_rel_cnt <= (r_state == ST_RELEASE) ? r_rel_cnt + 32'd1 : 32'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            if (w_xfer && ((r_state == ST_CNT_HI) || (r_state == ST_CNT_LO) || (r_state == ST_LOAD)))
                r_csum <= r_csum ^ i_rx_data;
`endif
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_rom_we    = w_rom_we;
    assign o_rom_addr  = r_rom_addr;
    assign o_rom_wdata = w_rom_wdata;

endmodule
